note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter WIDTH_COUNTER, default 10: width of note divider words, matching the downstream tone generator div input.
REQ-002 Parameter DEPTH_LOG2, default 4: log2 of note-table entries (16 steps).
REQ-003 Parameter BEAT_CYCLES, default 12000: clk cycles per beat; legal range 1..65535.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  write strobe for note table.
REQ-007 wr_addr  input  DEPTH_LOG2  table entry written.
REQ-008 wr_div  input  WIDTH_COUNTER  divider value stored in the entry.
REQ-009 wr_dur  input  4  duration field d; note lasts d+1 beats.
REQ-010 start  input  1  begin playback at step 0; sampled in IDLE only.
REQ-011 stop  input  1  abort playback.
REQ-012 loop  input  1  repeat mode, captured on the accepted start.
REQ-013 last_addr  input  DEPTH_LOG2  final step index, captured on the accepted start.
REQ-014 div  output  WIDTH_COUNTER  divider for downstream tone generator; registered.
REQ-015 gate  output  1  high while a note sounds; registered.
REQ-016 busy  output  1  high in LOAD or PLAY.
REQ-017 step  output  DEPTH_LOG2  current table index.
REQ-018 done  output  1  one-cycle pulse on natural end of non-loop playback.

Function
REQ-019 The block SHALL implement states IDLE, LOAD, PLAY.
REQ-020 The note table SHALL be 2^DEPTH_LOG2 x (WIDTH_COUNTER+4) storage, written in one cycle when wr_en=1, in any state.
REQ-021 In IDLE, start=1 and stop=0 SHALL set step=0, capture loop/last_addr, and enter LOAD next cycle.
REQ-022 LOAD SHALL last exactly one cycle with gate=0, read entry[step] (read-before-write on address collision), and enter PLAY.
REQ-023 On entering PLAY, div and the duration counter SHALL load from the read entry, gate SHALL go to 1, and the beat prescaler SHALL clear.
REQ-024 PLAY SHALL last exactly (d+1)*BEAT_CYCLES cycles; on its final cycle: if step!=last_addr, step<=step+1 and go to LOAD; else if loop, step<=0 and go to LOAD; else go to IDLE, gate<=0, done pulse 1.
REQ-025 Step period SHALL therefore be (d+1)*BEAT_CYCLES+1 cycles, the one-cycle gate-low gap separating notes.
REQ-026 div SHALL hold its last value in IDLE and in LOAD.
REQ-027 stop=1 in LOAD or PLAY SHALL force IDLE next cycle, gate=0, no done pulse; stop wins over start and over note-end.
REQ-028 start while busy SHALL be ignored.
REQ-029 A write to the playing entry SHALL not alter the current note; it takes effect on the next visit.
REQ-030 last_addr=2^DEPTH_LOG2-1 SHALL be legal; step never wraps except via loop restart.

Reset
REQ-031 rst=1 SHALL force IDLE, div=0, gate=0, busy=0, step=0, done=0 on the next edge, overriding all inputs including mid-playback.
REQ-032 Note table contents SHALL NOT be reset.

Configuration
REQ-033 With NOTE_SEQ_REST_EN defined, an entry with div=0 SHALL be a rest: PLAY timing unchanged, gate=0, div output holds previous value.
REQ-034 Without NOTE_SEQ_REST_EN, div=0 entries SHALL play as ordinary notes (gate=1, div=0).

Verification (BEAT_CYCLES=4)
REQ-035 Write entries 0:(div 100,d 0),1:(200,1); last_addr=1, loop=0, start -> busy 1 cycle later; gate high 4 cycles div=100, 1 gap, 8 cycles div=200, then done pulse, busy=0.
REQ-036 Same table, loop=1 -> step sequence 0,1,0,1...; period 14 cycles; no done pulse.
REQ-037 stop asserted mid-note of step 1 -> next cycle IDLE, gate 0, done 0, div holds 200.
REQ-038 rst during PLAY -> all outputs reset values next edge; later start replays from step 0.
REQ-039 Entry 1 div=0, with NOTE_SEQ_REST_EN -> gate low 8 cycles, div stays 100; without -> gate high, div=0.
REQ-040 Write entry 0 (div 300) while entry 0 plays with loop=1 -> current note keeps div 100; next pass div 300.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: plays a writable table of (divider, duration) notes to a tone generator.
// Optional feature macro NOTE_SEQ_REST_EN: entries with div=0 become silent rests.
module note_sequencer #(
    parameter int WIDTH_COUNTER = 10,
    parameter int DEPTH_LOG2    = 4,
    parameter int BEAT_CYCLES   = 12000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DEPTH_LOG2-1:0]    wr_addr,
    input  logic [WIDTH_COUNTER-1:0] wr_div,
    input  logic [3:0]               wr_dur,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic [DEPTH_LOG2-1:0]    last_addr,
    output logic [WIDTH_COUNTER-1:0] div,
    output logic                     gate,
    output logic                     busy,
    output logic [DEPTH_LOG2-1:0]    step,
    output logic                     done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [15:0] BEAT_LAST = 16'(BEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t                    state, state_nxt;
    logic [WIDTH_COUNTER+3:0]  table_mem [DEPTH];
    logic [WIDTH_COUNTER-1:0]  rd_div;
    logic [3:0]                rd_dur;
    logic [15:0]               beat_cnt, beat_cnt_nxt;
    logic [3:0]                beats_left, beats_left_nxt;
    logic [WIDTH_COUNTER-1:0]  div_nxt;
    logic                      gate_nxt, done_nxt, loop_q, loop_nxt;
    logic [DEPTH_LOG2-1:0]     step_nxt, last_q, last_nxt;

    // Table is deliberately left out of reset so a loaded tune survives it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[wr_addr] <= {wr_dur, wr_div};
        end
    end

    assign {rd_dur, rd_div} = table_mem[step];
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div        <= '0;
            gate       <= 1'b0;
            step       <= '0;
            done       <= 1'b0;
            beat_cnt   <= '0;
            beats_left <= '0;
            loop_q     <= 1'b0;
            last_q     <= '0;
        end else begin
            state      <= state_nxt;
            div        <= div_nxt;
            gate       <= gate_nxt;
            step       <= step_nxt;
            done       <= done_nxt;
            beat_cnt   <= beat_cnt_nxt;
            beats_left <= beats_left_nxt;
            loop_q     <= loop_nxt;
            last_q     <= last_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        div_nxt        = div;
        gate_nxt       = gate;
        step_nxt       = step;
        done_nxt       = 1'b0;
        beat_cnt_nxt   = beat_cnt;
        beats_left_nxt = beats_left;
        loop_nxt       = loop_q;
        last_nxt       = last_q;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    step_nxt  = '0;
                    loop_nxt  = loop;
                    last_nxt  = last_addr;
                    state_nxt = LOAD;
                end
            end

            LOAD: begin
                if (stop) begin
                    state_nxt = IDLE;
                    gate_nxt  = 1'b0;
                end else begin
                    state_nxt      = PLAY;
                    beat_cnt_nxt   = '0;
                    beats_left_nxt = rd_dur;
`ifdef NOTE_SEQ_REST_EN
                    if (rd_div != '0) begin
                        div_nxt  = rd_div;
                        gate_nxt = 1'b1;
                    end
`else
                    div_nxt  = rd_div;
                    gate_nxt = 1'b1;
`endif
                end
            end

            PLAY: begin
                // Stop outranks the note-end decision, so an abort never pulses done.
                if (stop) begin
                    state_nxt = IDLE;
                    gate_nxt  = 1'b0;
                end else if (beat_cnt == BEAT_LAST) begin
                    if (beats_left == 4'd0) begin
                        gate_nxt = 1'b0;
                        if (step != last_q) begin
                            step_nxt  = step + 1'b1;
                            state_nxt = LOAD;
                        end else if (loop_q) begin
                            step_nxt  = '0;
                            state_nxt = LOAD;
                        end else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        beat_cnt_nxt   = '0;
                        beats_left_nxt = beats_left - 4'd1;
                    end
                end else begin
                    beat_cnt_nxt = beat_cnt + 16'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
                gate_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: drives note_sequencer with directed and random playbacks and
// compares every cycle against a note-timeline model built from the table contents.
module tb_note_sequencer;

    localparam int BEAT  = 4;
    localparam int LIMIT = 300;

    typedef struct packed {
        logic       busy;
        logic       gate;
        logic [9:0] div;
        logic [3:0] step;
        logic       done;
    } obs_t;

    logic       clk, rst, wr_en, start, stop, loop;
    logic [3:0] wr_addr, wr_dur, last_addr, step;
    logic [9:0] wr_div, div;
    logic       gate, busy, done;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ref_div [16];
    int   ref_dur [16];
    int   model_div = 0;
    obs_t exp_q [$];
    obs_t obs_q [$];

    note_sequencer #(.WIDTH_COUNTER(10), .DEPTH_LOG2(4), .BEAT_CYCLES(BEAT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_div(wr_div),
        .wr_dur(wr_dur), .start(start), .stop(stop), .loop(loop), .last_addr(last_addr),
        .div(div), .gate(gate), .busy(busy), .step(step), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic obs_t mk(input bit b, input bit g, input int dv, input int st, input bit d);
        obs_t o;
        o.busy = b;
        o.gate = g;
        o.div  = 10'(dv);
        o.step = 4'(st);
        o.done = d;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.busy = busy;
        o.gate = gate;
        o.div  = div;
        o.step = step;
        o.done = done;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("busy=%0b gate=%0b div=%0d step=%0d done=%0b",
                         o.busy, o.gate, o.div, o.step, o.done);
    endfunction

    // Timeline model: each note is a one-cycle load gap followed by (d+1)*BEAT sounding cycles.
    task automatic model_build(input int last, input bit lp, input int stop_at, input int rst_at,
                               input int wr_at, input int wa, input int wd, input int wdur);
        int   s, cur, cut;
        bit   wr_done, g;
        obs_t e;
        s = 0;
        cur = model_div;
        wr_done = 1'b0;
        exp_q.delete();
        while (exp_q.size() < LIMIT) begin
            if (!wr_done && wr_at >= 0 && wr_at < exp_q.size()) begin
                ref_div[wa] = wd;
                ref_dur[wa] = wdur;
                wr_done = 1'b1;
            end
            exp_q.push_back(mk(1, 0, cur, s, 0));
            g = 1'b1;
`ifdef NOTE_SEQ_REST_EN
            if (ref_div[s] == 0) g = 1'b0;
            else cur = ref_div[s];
`else
            cur = ref_div[s];
`endif
            repeat ((ref_dur[s] + 1) * BEAT) exp_q.push_back(mk(1, g, cur, s, 0));
            if (s != last) s++;
            else if (lp) s = 0;
            else begin
                exp_q.push_back(mk(0, 0, cur, s, 1));
                exp_q.push_back(mk(0, 0, cur, s, 0));
                break;
            end
        end
        cut = -1;
        if (stop_at >= 0) cut = stop_at;
        if (rst_at >= 0 && (cut < 0 || rst_at < cut)) cut = rst_at;
        if (cut >= 0 && cut < exp_q.size()) begin
            e = exp_q[cut];
            while (exp_q.size() > cut + 1) void'(exp_q.pop_back());
            if (cut == rst_at) e = mk(0, 0, 0, 0, 0);
            else e = mk(0, 0, e.div, e.step, 0);
            exp_q.push_back(e);
            exp_q.push_back(e);
        end
        if (!wr_done && wr_at >= 0 && wr_at < exp_q.size()) begin
            ref_div[wa] = wd;
            ref_dur[wa] = wdur;
        end
        model_div = exp_q[exp_q.size() - 1].div;
    endtask

    task automatic write_entry(input int a, input int dv, input int dr);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_div = 10'(dv);
        wr_dur = 4'(dr);
        @(negedge clk);
        wr_en = 1'b0;
        ref_div[a] = dv;
        ref_dur[a] = dr;
    endtask

    // Starts a playback and records one observation per cycle, beginning with the load cycle.
    task automatic run_play(input int last, input bit lp, input int stop_at, input int rst_at,
                            input int wr_at, input int wa, input int wd, input int wdur,
                            input int ign_at);
        model_build(last, lp, stop_at, rst_at, wr_at, wa, wd, wdur);
        obs_q.delete();
        @(negedge clk);
        start = 1'b1;
        loop = lp;
        last_addr = 4'(last);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            obs_q.push_back(sample());
            wr_en = 1'b0;
            stop  = 1'b0;
            rst   = 1'b0;
            start = 1'b0;
            if (i == wr_at) begin
                wr_en = 1'b1;
                wr_addr = 4'(wa);
                wr_div = 10'(wd);
                wr_dur = 4'(wdur);
            end
            if (i == stop_at) stop = 1'b1;
            if (i == rst_at) rst = 1'b1;
            if (i == ign_at) begin
                start = 1'b1;
                loop = ~lp;
                last_addr = ~last_addr;
            end
        end
        wr_en = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        o = sample();
        n_checks++;
        if (o !== mk(0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %s, expected %s", fmt(o), fmt(mk(0, 0, 0, 0, 0)));
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            o = sample();
            n_checks++;
            if (o !== mk(0, 0, 0, 0, 0)) begin
                n_fail++;
                $display("[TB] FAIL reset_idle: got %s, expected %s", fmt(o), fmt(mk(0, 0, 0, 0, 0)));
            end
        end
        model_div = 0;
    endtask

    task automatic test_basic();
        write_entry(0, 100, 0);
        write_entry(1, 200, 1);
        run_play(1, 0, -1, -1, -1, 0, 0, 0, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL basic cyc %0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_loop();
        run_play(1, 1, 40, -1, -1, 0, 0, 0, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL loop cyc %0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_stop();
        run_play(1, 0, 9, -1, -1, 0, 0, 0, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL stop cyc %0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        run_play(1, 0, -1, 7, -1, 0, 0, 0, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL reset_mid cyc %0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
        run_play(1, 0, -1, -1, -1, 0, 0, 0, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL replay cyc %0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_rest();
        write_entry(1, 0, 1);
        run_play(1, 0, -1, -1, -1, 0, 0, 0, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL rest cyc %0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
        write_entry(1, 200, 1);
    endtask

    task automatic test_write_during_play();
        run_play(1, 1, 30, -1, 2, 0, 300, 0, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL wr_play cyc %0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_start_ignored();
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL start_with_stop: got busy=%0b, expected busy=0", busy);
        end
    endtask

    task automatic test_last_max();
        for (int a = 0; a < 16; a++) write_entry(a, a * 37 + 5, a % 2);
        run_play(15, 0, -1, -1, -1, 0, 0, 0, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL last_max cyc %0d: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_random();
        int  last, stop_at, wr_at, wa, wd, wdur, dv;
        bit  lp;
        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < 4; a++) begin
                dv = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 1023));
                write_entry(a, dv, int'($urandom_range(0, 3)));
            end
            last = int'($urandom_range(0, 3));
            lp   = 1'($urandom_range(0, 1));
            if (lp) stop_at = int'($urandom_range(10, 60));
            else if ($urandom_range(0, 2) == 0) stop_at = int'($urandom_range(6, 20));
            else stop_at = -1;
            wr_at = int'($urandom_range(0, 4));
            wa    = int'($urandom_range(0, 3));
            wd    = int'($urandom_range(0, 1023));
            wdur  = int'($urandom_range(0, 3));
            run_play(last, lp, stop_at, -1, wr_at, wa, wd, wdur, 2);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL random%0d cyc %0d: got %s, expected %s",
                             t, i, fmt(obs_q[i]), fmt(exp_q[i]));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_div = '0;
        wr_dur = '0;
        start = 1'b0;
        stop = 1'b0;
        loop = 1'b0;
        last_addr = '0;
        test_reset();
        test_basic();
        test_loop();
        test_stop();
        test_reset_mid();
        test_rest();
        test_write_during_play();
        test_start_ignored();
        test_last_max();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
